mem_capture: RTL and testbench

Parametrised multi-channel sample capture buffer for the systolic filter datapath. It records filter output samples into per-channel on-chip memories under an arm/stop protocol, in one-shot or circular mode. Captured data is read back through a registered read port for bench checking or export. It replaces the free-running, uncontrolled store-every-clock capture with gated, resettable, readable capture.

---
 rtl/mem_capture.sv | 134 +++++++++++++
 tb/tb_mem_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mem_capture
// | Multi-channel sample capture buffer with arm/stop control, one-shot or
// | circular recording, and a registered read-back port.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module mem_capture #(
    parameter int DW  = 20,
    parameter int AW  = 10,
    parameter int NCH = 1,
    localparam int c_CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] dstore,
    input  logic              dstore_valid,
    input  logic              arm,
    input  logic              mode,
    input  logic              stop,
    input  logic              rd_en,
    input  logic [c_CW-1:0]   rd_ch,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [AW:0]       wr_count,
    output logic [AW-1:0]     oldest_addr
);

    localparam int            c_DEPTH     = 2**AW;
    localparam int            c_NSEL      = 2**c_CW;
    localparam logic [AW:0]   c_DEPTH_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] c_LAST      = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_wr_count;
    logic            r_wrapped;
    logic            r_mode;
    logic            w_wr_en;
    logic [DW-1:0]   w_bank_rd [c_NSEL];

    // A restarting arm discards any sample presented in the same cycle.
    assign w_wr_en = (r_state == S_RUN) && dstore_valid && !arm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) w_next = S_RUN;
            end
            S_RUN: begin
                if (!arm) begin
                    if (r_mode && stop)
                        w_next = S_DONE;
                    else if (!r_mode && dstore_valid && (r_wr_ptr == c_LAST))
                        w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_wrapped  <= 1'b0;
            r_mode     <= 1'b0;
        end else if (arm) begin
            r_wr_ptr   <= '0;
            r_wr_count <= '0;
            r_wrapped  <= 1'b0;
            r_mode     <= mode;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_wr_count != c_DEPTH_CNT)
                r_wr_count <= r_wr_count + (AW+1)'(1);
            if (r_mode && (r_wr_ptr == c_LAST))
                r_wrapped <= 1'b1;
        end
    end

    assign wrapped     = r_wrapped;
    assign wr_count    = r_wr_count;
    assign oldest_addr = r_wrapped ? r_wr_ptr : '0;

    // Unpopulated select codes read as zero; memory contents are never reset.
    for (genvar c = 0; c < c_NSEL; c++) begin : g_bank
        if (c < NCH) begin : g_mem
            logic [DW-1:0] r_mem [c_DEPTH];
            always_ff @(posedge clk) begin
                if (w_wr_en) r_mem[r_wr_ptr] <= dstore[c*DW +: DW];
            end
            assign w_bank_rd[c] = r_mem[rd_addr];
        end else begin : g_pad
            assign w_bank_rd[c] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= w_bank_rd[rd_ch];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_mem_capture
// | Scenario and randomized checks of mem_capture against a behavioural model.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_mem_capture;

    localparam int DW    = 20;
    localparam int AW    = 4;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] dstore;
    logic              dstore_valid;
    logic              arm;
    logic              mode;
    logic              stop;
    logic              rd_en;
    logic [0:0]        rd_ch;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              wrapped;
    logic [AW:0]       wr_count;
    logic [AW-1:0]     oldest_addr;

    int total = 0;
    int bad   = 0;

    // Model: capture is described by the number of samples accepted since arm.
    bit          m_run, m_done, m_mode;
    int          m_n;
    logic [19:0] m_mem [NCH][DEPTH];
    bit          m_known [NCH][DEPTH];
    logic [19:0] m_rd;
    bit          m_rdv, m_rd_known;

    mem_capture #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .dstore(dstore), .dstore_valid(dstore_valid),
        .arm(arm), .mode(mode), .stop(stop), .rd_en(rd_en), .rd_ch(rd_ch),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .done(done), .wrapped(wrapped), .wr_count(wr_count), .oldest_addr(oldest_addr)
    );

    always #5 clk = ~clk;

    function automatic int exp_count();
        return (m_n > DEPTH) ? DEPTH : m_n;
    endfunction

    function automatic bit exp_wrapped();
        return m_mode && (m_n >= DEPTH);
    endfunction

    function automatic int exp_oldest();
        return exp_wrapped() ? (m_n % DEPTH) : 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_mode = 0; m_n = 0;
        m_rd = '0; m_rdv = 0; m_rd_known = 1;
    endtask

    task automatic idle_inputs();
        dstore_valid = 0; arm = 0; mode = 0; stop = 0; rd_en = 0;
    endtask

    task automatic set_pair(input int a, input int b);
        dstore = {20'(b), 20'(a)};
    endtask

    task automatic tick();
        if (rd_en) begin
            m_rdv      = 1;
            m_rd       = m_mem[rd_ch][rd_addr];
            m_rd_known = m_known[rd_ch][rd_addr];
        end else begin
            m_rdv = 0;
        end
        if (arm) begin
            m_run = 1; m_done = 0; m_n = 0; m_mode = mode;
        end else if (m_run) begin
            if (dstore_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    m_mem[c][m_n % DEPTH]   = dstore[c*DW +: DW];
                    m_known[c][m_n % DEPTH] = 1;
                end
                m_n++;
            end
            if (m_mode && stop) begin
                m_run = 0; m_done = 1;
            end else if (!m_mode && m_n == DEPTH) begin
                m_run = 0; m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); dstore = '0; rd_ch = 0; rd_addr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL reset_state busy=%0b done=%0b required 0/0", busy, done); end
        total++; if (wr_count !== '0 || wrapped !== 1'b0 || oldest_addr !== '0) begin bad++;
            $display("FAIL reset_counts wr_count=%0d wrapped=%0b oldest=%0d required 0", wr_count, wrapped, oldest_addr); end
        total++; if (rd_data !== '0 || rd_valid !== 1'b0) begin bad++;
            $display("FAIL reset_read rd_data=%0h rd_valid=%0b required 0/0", rd_data, rd_valid); end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1; rd_ch = 0; rd_addr = AW'(i);
            tick();
            total++; if (rd_valid !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wr_count !== '0) begin bad++;
                $display("FAIL reset_readback i=%0d rd_valid=%0b busy=%0b done=%0b wr_count=%0d", i, rd_valid, busy, done, wr_count); end
        end
        rd_en = 0;
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++;
            $display("FAIL reset_rdvalid_drop got=%0b required 0", rd_valid); end
    endtask

    task automatic test_oneshot();
        arm = 1; mode = 0; tick(); arm = 0;
        total++; if (busy !== 1'b1 || wr_count !== '0) begin bad++;
            $display("FAIL oneshot_arm busy=%0b wr_count=%0d required 1/0", busy, wr_count); end
        for (int k = 0; k < 17; k++) begin
            dstore_valid = 1; set_pair(k, -k); tick();
            if (k == 14) begin
                total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++;
                    $display("FAIL oneshot_before_last busy=%0b done=%0b", busy, done); end
            end
            if (k == 15) begin
                total++; if (done !== 1'b1 || busy !== 1'b0 || wr_count !== 5'd16 || wrapped !== 1'b0) begin bad++;
                    $display("FAIL oneshot_last done=%0b busy=%0b wr_count=%0d wrapped=%0b required 1/0/16/0", done, busy, wr_count, wrapped); end
            end
        end
        dstore_valid = 0;
        total++; if (wr_count !== 5'd16 || done !== 1'b1) begin bad++;
            $display("FAIL oneshot_ignore wr_count=%0d done=%0b required 16/1", wr_count, done); end
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < DEPTH; k++) begin
                rd_en = 1; rd_ch = 1'(c); rd_addr = AW'(k); tick();
                total++; if (rd_data !== ((c == 0) ? 20'(k) : 20'(-k))) begin bad++;
                    $display("FAIL oneshot_readback ch=%0d addr=%0d got=%0h required=%0h", c, k, rd_data, (c == 0) ? 20'(k) : 20'(-k)); end
            end
        end
        rd_en = 0;
    endtask

    task automatic test_circular();
        arm = 1; mode = 1; tick(); arm = 0; mode = 0;
        for (int k = 0; k < 20; k++) begin
            dstore_valid = 1; set_pair(k, -k); tick();
        end
        dstore_valid = 0; stop = 1; tick(); stop = 0;
        total++; if (wrapped !== 1'b1 || wr_count !== 5'd16 || oldest_addr !== 4'd4 || done !== 1'b1) begin bad++;
            $display("FAIL circ_status wrapped=%0b wr_count=%0d oldest=%0d done=%0b required 1/16/4/1", wrapped, wr_count, oldest_addr, done); end
        for (int k = 0; k < DEPTH; k++) begin
            rd_en = 1; rd_ch = 0; rd_addr = AW'(k); tick();
            total++; if (rd_data !== 20'((k < 4) ? k + 16 : k)) begin bad++;
                $display("FAIL circ_readback addr=%0d got=%0h required=%0h", k, rd_data, 20'((k < 4) ? k + 16 : k)); end
        end
        rd_en = 0;
    endtask

    task automatic test_stop_coincident();
        arm = 1; mode = 1; tick(); arm = 0;
        for (int k = 0; k < 7; k++) begin
            dstore_valid = 1; set_pair(k + 32, k); tick();
        end
        set_pair(7 + 32, 7); stop = 1; tick(); stop = 0; dstore_valid = 0;
        total++; if (done !== 1'b1 || wr_count !== 5'd8) begin bad++;
            $display("FAIL stop_coinc done=%0b wr_count=%0d required 1/8", done, wr_count); end
        rd_en = 1; rd_ch = 0; rd_addr = 4'd7; tick(); rd_en = 0;
        total++; if (rd_data !== 20'd39) begin bad++;
            $display("FAIL stop_coinc_data got=%0h required=27", rd_data); end
    endtask

    task automatic test_rearm();
        arm = 1; mode = 1; tick(); arm = 0;
        for (int k = 0; k < 5; k++) begin
            dstore_valid = 1; set_pair(k + 64, 0); tick();
        end
        arm = 1; set_pair(20'h99, 20'h99); tick(); arm = 0;
        total++; if (wr_count !== '0 || busy !== 1'b1) begin bad++;
            $display("FAIL rearm_clear wr_count=%0d busy=%0b required 0/1", wr_count, busy); end
        set_pair(20'h123, 20'h456); tick(); dstore_valid = 0;
        rd_en = 1; rd_ch = 0; rd_addr = 4'd0; tick();
        total++; if (rd_data !== 20'h123 || wr_count !== 5'd1) begin bad++;
            $display("FAIL rearm_first got=%0h wr_count=%0d required 123/1", rd_data, wr_count); end
        rd_ch = 1; rd_addr = 4'd5; tick(); rd_en = 0;
        total++; if (rd_data !== 20'd5) begin bad++;
            $display("FAIL rearm_dropped got=%0h required 5", rd_data); end
    endtask

    task automatic test_read_during_write();
        arm = 1; mode = 0; tick(); arm = 0;
        for (int k = 0; k < 4; k++) begin
            dstore_valid = 1; set_pair((k == 3) ? 5 : k + 1, 0); tick();
        end
        arm = 1; dstore_valid = 0; tick(); arm = 0;
        for (int k = 0; k < 3; k++) begin
            dstore_valid = 1; set_pair(k + 1, 0); tick();
        end
        set_pair(20'h0000A, 0); rd_en = 1; rd_ch = 0; rd_addr = 4'd3; tick();
        dstore_valid = 0;
        total++; if (rd_data !== 20'h00005) begin bad++;
            $display("FAIL rw_same_addr got=%0h required=00005", rd_data); end
        tick(); rd_en = 0;
        total++; if (rd_data !== 20'h0000A) begin bad++;
            $display("FAIL rw_next_read got=%0h required=0000A", rd_data); end
    endtask

    task automatic test_async_reset();
        dstore_valid = 1; set_pair(20'h77, 20'h77); tick();
        total++; if (busy !== 1'b1 || wr_count !== 5'd5) begin bad++;
            $display("FAIL areset_pre busy=%0b wr_count=%0d required 1/5", busy, wr_count); end
        #2 rst_n = 0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || wr_count !== '0 || rd_valid !== 1'b0) begin bad++;
            $display("FAIL areset_immediate busy=%0b done=%0b wr_count=%0d rd_valid=%0b required 0", busy, done, wr_count, rd_valid); end
        model_reset(); idle_inputs();
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        total++; if (busy !== 1'b0 || rd_data !== '0) begin bad++;
            $display("FAIL areset_after busy=%0b rd_data=%0h required 0/0", busy, rd_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            arm          = ($urandom_range(0, 39) == 0);
            mode         = ($urandom_range(0, 2) != 0);
            stop         = ($urandom_range(0, 29) == 0);
            dstore_valid = ($urandom_range(0, 9) < 7);
            dstore       = 40'({$urandom(), $urandom()});
            rd_en        = $urandom_range(0, 1) == 1;
            rd_ch        = 1'($urandom_range(0, 1));
            rd_addr      = AW'($urandom_range(0, DEPTH - 1));
            tick();
            total++; if (busy !== m_run || done !== m_done) begin bad++;
                $display("FAIL rand_state cyc=%0d busy=%0b done=%0b required %0b/%0b", i, busy, done, m_run, m_done); end
            total++; if (wr_count !== 5'(exp_count()) || wrapped !== exp_wrapped() || oldest_addr !== 4'(exp_oldest())) begin bad++;
                $display("FAIL rand_track cyc=%0d wr_count=%0d wrapped=%0b oldest=%0d required %0d/%0b/%0d", i, wr_count, wrapped, oldest_addr, exp_count(), exp_wrapped(), exp_oldest()); end
            total++; if (rd_valid !== m_rdv || (m_rd_known && rd_data !== m_rd)) begin bad++;
                $display("FAIL rand_read cyc=%0d rd_valid=%0b rd_data=%0h required %0b/%0h", i, rd_valid, rd_data, m_rdv, m_rd); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_circular();
        test_stop_coincident();
        test_rearm();
        test_read_during_write();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
